// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: access selects, two-word sequencer states,
// and the MEM/WB pass-through bundle.
package memory_stage_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        ADDR_ALU      = 2'b00,
        ADDR_SP       = 2'b01,
        ADDR_SP_PLUS1 = 2'b10,
        ADDR_RSRC     = 2'b11
    } addr_sel_e;

    typedef enum logic [1:0] {
        SRC_RDST  = 2'b00,
        SRC_PC    = 2'b01,
        SRC_FLAGS = 2'b10,
        SRC_RSRC  = 2'b11
    } wsrc_sel_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PUSH_LO = 2'b01,
        POP_HI  = 2'b10
    } mem_state_e;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic [2:0]  reg_write_address;
        logic [15:0] ldm_value;
        logic        outport_enable;
        logic [15:0] inport_value;
        logic [15:0] alu_result;
    } wb_ctrl_t;

endpackage

// File: rtl/memory_stage_data_memory.sv
// Single-port data memory: synchronous write, combinational read.
module memory_stage_data_memory #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    logic [15:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: data-memory load/store, stack push/pop including
// two-cycle 32-bit PC push/pop, and the MEM/WB output register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] SP_RESET   = {ADDR_WIDTH{1'b1}}
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] alu_result,
    input  logic [15:0] read_data1,
    input  logic [15:0] read_data2,
    input  logic [31:0] pc_plus_one,
    input  logic [2:0]  flags_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_push,
    input  logic        mem_pop,
    input  logic [1:0]  memory_address_select,
    input  logic [1:0]  memory_write_src_select,
    input  logic        pc_choose_memory,
    input  logic        reg_write,
    input  logic [1:0]  wb_sel,
    input  logic [2:0]  reg_write_address,
    input  logic [15:0] LDM_value,
    input  logic        outport_enable,
    input  logic [15:0] inport_value,
    output logic        reg_write_out,
    output logic [1:0]  wb_sel_out,
    output logic [2:0]  reg_write_address_out,
    output logic [15:0] LDM_value_out,
    output logic        outport_enable_out,
    output logic [15:0] inport_value_out,
    output logic [15:0] alu_result_out,
    output logic [15:0] mem_data_out,
    output logic [31:0] pc_from_memory,
    output logic        pc_choose_memory_out,
    output logic [2:0]  conditions_from_memory_pop,
    output logic        stall
);

    mem_state_e            state, state_next;
    logic [ADDR_WIDTH-1:0] sp, sp_next;
    logic [ADDR_WIDTH-1:0] sel_addr, mem_addr, lat_addr;
    logic [15:0]           sel_wdata, mem_wdata, rdata, lat_data;
    logic                  mem_we, stall_int;
    logic                  do_push, do_pop, pc_push, pc_pop;
    wb_ctrl_t              in_ctrl, lat_ctrl, wb_q;

    assign in_ctrl = '{reg_write:         reg_write,
                       wb_sel:            wb_sel,
                       reg_write_address: reg_write_address,
                       ldm_value:         LDM_value,
                       outport_enable:    outport_enable,
                       inport_value:      inport_value,
                       alu_result:        alu_result};

    // Push wins over a simultaneous (illegal) pop.
    assign do_push = mem_push;
    assign do_pop  = mem_pop & ~mem_push;
    assign pc_push = do_push & (wsrc_sel_e'(memory_write_src_select) == SRC_PC);
    assign pc_pop  = do_pop & pc_choose_memory;

    always_comb begin
        sel_addr = alu_result[ADDR_WIDTH-1:0];
        case (addr_sel_e'(memory_address_select))
            ADDR_ALU:      sel_addr = alu_result[ADDR_WIDTH-1:0];
            ADDR_SP:       sel_addr = sp;
            ADDR_SP_PLUS1: sel_addr = sp + 1'b1;
            ADDR_RSRC:     sel_addr = read_data2[ADDR_WIDTH-1:0];
            default:       sel_addr = alu_result[ADDR_WIDTH-1:0];
        endcase
    end

    always_comb begin
        sel_wdata = read_data1;
        case (wsrc_sel_e'(memory_write_src_select))
            SRC_RDST:  sel_wdata = read_data1;
            SRC_PC:    sel_wdata = pc_plus_one[31:16];
            SRC_FLAGS: sel_wdata = {13'b0, flags_in};
            SRC_RSRC:  sel_wdata = read_data2;
            default:   sel_wdata = read_data1;
        endcase
    end

    always_comb begin
        state_next = state;
        sp_next    = sp;
        mem_we     = 1'b0;
        mem_addr   = sel_addr;
        mem_wdata  = sel_wdata;
        stall_int  = 1'b0;
        case (state)
            IDLE: begin
                mem_we = mem_write | do_push;
                if (pc_push) begin
                    stall_int  = 1'b1;
                    state_next = PUSH_LO;
                end else if (pc_pop) begin
                    stall_int  = 1'b1;
                    state_next = POP_HI;
                end else if (do_push) begin
                    sp_next = sp - 1'b1;
                end else if (do_pop) begin
                    sp_next = sp + 1'b1;
                end
            end
            // Second cycles run purely from latched address/data; inputs ignored.
            PUSH_LO: begin
                mem_we     = 1'b1;
                mem_addr   = lat_addr;
                mem_wdata  = lat_data;
                sp_next    = sp - ADDR_WIDTH'(2);
                state_next = IDLE;
            end
            POP_HI: begin
                mem_addr   = lat_addr;
                sp_next    = sp + ADDR_WIDTH'(2);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall = stall_int & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sp    <= SP_RESET;
        end else begin
            state <= state_next;
            sp    <= sp_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr                   <= '0;
            lat_data                   <= '0;
            lat_ctrl                   <= '0;
            wb_q                       <= '0;
            mem_data_out               <= '0;
            pc_from_memory             <= '0;
            pc_choose_memory_out       <= 1'b0;
            conditions_from_memory_pop <= '0;
        end else begin
            pc_choose_memory_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (stall_int) begin
                        // First half of a two-word op emits a bubble; the real
                        // MEM/WB entry comes out at the end of the second cycle.
                        wb_q     <= '0;
                        lat_ctrl <= in_ctrl;
                        lat_data <= pc_push ? pc_plus_one[15:0] : rdata;
                        lat_addr <= pc_push ? sel_addr - 1'b1 : sel_addr + 1'b1;
                    end else begin
                        wb_q <= in_ctrl;
                        if (mem_read | do_pop) mem_data_out <= rdata;
                        if (do_pop) conditions_from_memory_pop <= rdata[2:0];
                    end
                end
                PUSH_LO: wb_q <= lat_ctrl;
                POP_HI: begin
                    wb_q                 <= lat_ctrl;
                    pc_from_memory       <= {rdata, lat_data};
                    pc_choose_memory_out <= 1'b1;
                end
                default: wb_q <= '0;
            endcase
        end
    end

    assign reg_write_out         = wb_q.reg_write;
    assign wb_sel_out            = wb_q.wb_sel;
    assign reg_write_address_out = wb_q.reg_write_address;
    assign LDM_value_out         = wb_q.ldm_value;
    assign outport_enable_out    = wb_q.outport_enable;
    assign inport_value_out      = wb_q.inport_value;
    assign alu_result_out        = wb_q.alu_result;

    generate
        if (ADDR_WIDTH < 16) begin : g_unused_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^{alu_result[15:ADDR_WIDTH], read_data2[15:ADDR_WIDTH]};
        end
    endgenerate

    memory_stage_data_memory #(.ADDR_WIDTH(ADDR_WIDTH)) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (rdata)
    );

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage placed directly downstream of the execute stage. It consumes the EX/MEM buffered ALU result, operands and control, and performs data-memory load/store and stack push/pop, including two-word 32-bit PC push/pop. It produces the MEM/WB buffer for write-back, the popped PC for redirection, and popped flags for the ALU. It owns the data memory and the stack pointer.

## Interface
- ADDR_WIDTH, 12: data-memory address bits; depth 2^ADDR_WIDTH 16-bit words.
- SP_RESET, 2^ADDR_WIDTH-1: stack pointer value after reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- alu_result  in  16  EX/MEM ALU result; the load/store address.
- read_data1, read_data2  in  16 each  forwarded Rdest/Rsrc from EX/MEM.
- pc_plus_one  in  32  return PC for CALL/INT.
- flags_in  in  3  EX flag register {C,N,Z}.
- mem_read, mem_write, mem_push, mem_pop  in  1 each  access type.
- memory_address_select  in  2  00 ALU result, 01 SP (push), 10 SP+1 (pop), 11 read_data2.
- memory_write_src_select  in  2  00 read_data1, 01 pc_plus_one (two-word), 10 {13'b0,flags_in}, 11 read_data2.
- pc_choose_memory  in  1  pop is a 32-bit PC (RET/RTI).
- reg_write, wb_sel[1:0], reg_write_address[2:0], LDM_value[15:0], outport_enable, inport_value[15:0]  in  pass-through control/data.
- *_out for each pass-through  out  same width  MEM/WB registered copy.
- alu_result_out  out  16  registered alu_result.
- mem_data_out  out  16  registered read data.
- pc_from_memory  out  32  popped PC {high,low}.
- pc_choose_memory_out  out  1  one-cycle pulse: pc_from_memory valid.
- conditions_from_memory_pop  out  3  mem_data_out[2:0] when the pop is a flags pop.
- stall  out  1  combinational; upstream must hold stages while high.

## Operation
- FSM states: IDLE, PUSH_LO, POP_HI.
- IDLE, single-word: mem_write or mem_push writes the selected source to the selected address. mem_read or mem_pop reads the selected address into mem_data_out.
- Push: write at SP, then SP <= SP-1. Pop: read at SP+1, then SP <= SP+1.
- PC push (mem_push and write src 01): IDLE writes pc_plus_one[31:16] at SP, latches the low half and SP-1, asserts stall, and goes to PUSH_LO. PUSH_LO writes the low half at SP-1 and sets SP <= SP-2, then returns to IDLE.
- PC pop (mem_pop and pc_choose_memory): IDLE reads the low word at SP+1, latches it, asserts stall, and goes to POP_HI. POP_HI reads the high word at SP+2, sets SP <= SP+2, and registers pc_from_memory = {high,low} with pc_choose_memory_out=1.
- During PUSH_LO and POP_HI all inputs are ignored. Latched values are used instead. Pass-through outputs are registered from the latched first-cycle control, so exactly one MEM/WB entry is produced.
- Addresses and SP are mod 2^ADDR_WIDTH. SP 0 minus 1 wraps to all-ones; all-ones plus 1 wraps to 0.
- mem_read and mem_write together at one address: the write is performed and mem_data_out returns the prior contents.
- Push and pop together: illegal. Push takes priority and the pop is ignored.
- No access flags set: memory and SP are unchanged, and mem_data_out holds its previous value.
- Reset mid PUSH_LO/POP_HI: FSM goes to IDLE and SP to SP_RESET. Partially written memory is not restored. Memory contents are not cleared by reset.

## Timing
- Latency is one cycle from EX/MEM inputs to MEM/WB outputs. A two-word op takes two cycles and produces one output, registered at the end of the second cycle.
- stall is high only in the first cycle of a two-word op.
- Reset values: every *_out 0, mem_data_out 0, pc_from_memory 0, pc_choose_memory_out 0, conditions_from_memory_pop 0, stall 0, SP = SP_RESET, FSM IDLE.
- Memory write is synchronous on the rising edge. Memory read is combinational and captured into mem_data_out on the same edge.

## Structure
- Shared package holds:
  - the address-select enum (ALU, SP, SP_PLUS1, RSRC);
  - the write-source enum (RDST, PC, FLAGS, RSRC);
  - the FSM state enum;
  - the default ADDR_WIDTH.
- One sub-module, data_memory: 2^ADDR_WIDTH x 16, single port, synchronous write, combinational read.

## Test plan
- Store/load: mem_write with alu_result=0x0010 and read_data1=0xBEEF; next cycle mem_read at 0x0010 -> mem_data_out=0xBEEF.
- Push/pop: push read_data1=0x1234 -> SP 0xFFF->0xFFE and mem[0xFFF]=0x1234; pop -> mem_data_out=0x1234 and SP=0xFFF.
- PC push: pc_plus_one=0x0001_0203 -> stall high for one cycle; mem[0xFFF]=0x0001, mem[0xFFE]=0x0203, SP=0xFFD.
- PC pop directly after the PC push -> stall for one cycle; pc_from_memory=0x0001_0203 with a one-cycle pc_choose_memory_out pulse; SP=0xFFF.
- Wrap and reset: pop at SP=0xFFF -> SP=0x000. Assert reset during PUSH_LO -> FSM IDLE, SP=0xFFF, all outputs 0.
- Flags pop: push flags_in=3'b101, then pop -> conditions_from_memory_pop=3'b101.
